// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings for the byte-serial memory controller
package mem_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, WAIT_IO, DONE} state_t;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b11;
  localparam logic [1:0] IO_HI = 2'b11;
  localparam logic RAM_WRITE = 1'b1;
  localparam logic RAM_READ = 1'b0;
  function automatic logic [2:0] nbytes(input logic [1:0] sz);
    return sz == SZ_B ? 3'd1 : sz == SZ_H ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises IF fetches and MEM loads/stores onto a byte-wide synchronous RAM/IO port
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter logic [1:0] IO_HI = mem_ctrl_pkg::IO_HI
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_done_o,
  output logic [31:0]       if_data_o,
  input  logic              mem_r_req_i,
  input  logic              mem_w_req_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_w_data_i,
  input  logic [1:0]        mem_state_i,
  output logic              mem_done_o,
  output logic [31:0]       mem_r_data_o,
  input  logic              io_buffer_full_i,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
);
  import mem_ctrl_pkg::*;
  state_t state, state_n;
  logic [1:0] cnt, cnt_n;
  logic pend, pend_n, is_if, is_if_n, wr_n, last, io;
  logic [2:0] n, n_n, nxt;
  logic [ADDR_W-1:0] base, base_n, a_n;
  logic [31:0] wdata, wdata_n, asm_q, asm_n, if_data_q, if_data_n, mem_data_n;
  logic [7:0] dout_n;
  assign last = {1'b0, cnt} == n - 3'd1;
  assign io = base[17:16] == IO_HI;
  // pend means ram_din_i currently carries byte cnt; nxt is the next byte index to address
  assign nxt = pend ? {1'b0, cnt} + 3'd2 : 3'd1;
  assign if_done_o = state == DONE && is_if && !if_flush_i;
  assign mem_done_o = state == DONE && !is_if;
  assign if_data_o = if_done_o ? asm_q : if_data_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      pend <= 1'b0;
      is_if <= 1'b0;
      n <= '0;
      base <= '0;
      wdata <= '0;
      asm_q <= '0;
      if_data_q <= '0;
      mem_r_data_o <= '0;
      ram_a_o <= '0;
      ram_wr_o <= RAM_READ;
      ram_dout_o <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pend <= pend_n;
      is_if <= is_if_n;
      n <= n_n;
      base <= base_n;
      wdata <= wdata_n;
      asm_q <= asm_n;
      if_data_q <= if_data_n;
      mem_r_data_o <= mem_data_n;
      ram_a_o <= a_n;
      ram_wr_o <= wr_n;
      ram_dout_o <= dout_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    pend_n = pend;
    is_if_n = is_if;
    n_n = n;
    base_n = base;
    wdata_n = wdata;
    asm_n = asm_q;
    if_data_n = if_data_q;
    mem_data_n = mem_r_data_o;
    a_n = ram_a_o;
    wr_n = RAM_READ;
    dout_n = ram_dout_o;
    case (state)
      IDLE: begin
        if (mem_r_req_i || mem_w_req_i) begin
          is_if_n = 1'b0;
          base_n = mem_addr_i;
          wdata_n = mem_w_data_i;
          n_n = nbytes(mem_state_i);
          cnt_n = '0;
          pend_n = 1'b0;
          asm_n = '0;
          a_n = mem_addr_i;
          if (!mem_w_req_i) state_n = MEM_RD;
          else if (mem_addr_i[17:16] == IO_HI && io_buffer_full_i) state_n = WAIT_IO;
          else begin
            state_n = MEM_WR;
            wr_n = RAM_WRITE;
            dout_n = mem_w_data_i[7:0];
          end
        end else if (if_req_i) begin
          state_n = IF_RD;
          is_if_n = 1'b1;
          base_n = if_addr_i;
          n_n = 3'd4;
          cnt_n = '0;
          pend_n = 1'b0;
          asm_n = '0;
          a_n = if_addr_i;
        end
      end
      IF_RD, MEM_RD: begin
        if (state == IF_RD && if_flush_i) state_n = IDLE;
        else begin
          pend_n = 1'b1;
          if (nxt < n) a_n = base + ADDR_W'(nxt);
          if (pend) begin
            asm_n[{cnt, 3'b000} +: 8] = ram_din_i;
            cnt_n = cnt + 2'd1;
            if (last) begin
              state_n = DONE;
              if (!is_if) mem_data_n = asm_n;
            end
          end
        end
      end
      MEM_WR: begin
        if (last) state_n = DONE;
        else begin
          cnt_n = cnt + 2'd1;
          if (io && io_buffer_full_i) state_n = WAIT_IO;
          else begin
            wr_n = RAM_WRITE;
            a_n = base + ADDR_W'(cnt_n);
            dout_n = wdata[{cnt_n, 3'b000} +: 8];
          end
        end
      end
      WAIT_IO: begin
        if (!io_buffer_full_i) begin
          state_n = MEM_WR;
          wr_n = RAM_WRITE;
          a_n = base + ADDR_W'(cnt);
          dout_n = wdata[{cnt, 3'b000} +: 8];
        end
      end
      DONE: begin
        state_n = IDLE;
        if (is_if && !if_flush_i) if_data_n = asm_q;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
